instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit for the FPGA Forth core. It sits directly downstream of the program counter. It consumes `pc_value` and steers the PC through `pc_mode`. It issues one-at-a-time 32-bit reads to instruction memory and buffers returned words, tagged with their address, in a small FIFO that feeds the decoder over a valid/ready handshake. A `flush` input discards buffered and in-flight words when control flow changes.

## Interface
- `DEPTH`, 2: FIFO entries, power of two, ≥ 2.
- `clock  in  1`: single clock; all state changes on its rising edge.
- `reset_n  in  1`: synchronous, active-low reset.
- `pc_value  in  32`: current PC from the program counter.
- `pc_mode  out  3`: PC command. 0 = reset, 1 = load from data bus, 3 = hold, 4 = increment.
- `flush  in  1`: control-flow change. The external driver places the target on the data bus this cycle.
- `mem_req  out  1`: read request; held high until `mem_ack`.
- `mem_addr  out  32`: read address, stable while `mem_req` is high.
- `mem_ack  in  1`: read complete; `mem_rdata` is valid in the same cycle.
- `mem_rdata  in  32`: read data.
- `instr_valid  out  1`: FIFO head is valid.
- `instr_data  out  32`: instruction word at the FIFO head.
- `instr_pc  out  32`: address of `instr_data`.
- `instr_ready  in  1`: decoder accepts the head word.

## Operation
- **States:** IDLE, REQ, DRAIN. The state register and FIFO are registered; `pc_mode` is combinational.
- **Reset:** while `reset_n` is low:
  - state → IDLE, FIFO count → 0, `mem_addr` → 0;
  - `mem_req` = 0, `instr_valid` = 0, `instr_data` = 0, `instr_pc` = 0;
  - `pc_mode` = 0.
  - Reset mid-REQ abandons the request; the memory must tolerate request withdrawal.
- **IDLE**
  - `pc_mode` = 3.
  - If `flush` = 1: `pc_mode` = 1, clear FIFO, stay in IDLE.
  - Else if count < DEPTH: latch `mem_addr` ← `pc_value` and go to REQ.
- **REQ**
  - `mem_req` = 1.
  - No `mem_ack`, no `flush`: `pc_mode` = 3, stay in REQ.
  - `mem_ack`, no `flush`: push {`mem_addr`, `mem_rdata`}, `pc_mode` = 4, go to IDLE.
  - `flush` with `mem_ack`: discard the data, `pc_mode` = 1, clear FIFO, go to IDLE.
  - `flush` without `mem_ack`: `pc_mode` = 1, clear FIFO, go to DRAIN.
- **DRAIN**
  - `mem_req` = 1 and `pc_mode` = 3.
  - On `mem_ack`: discard the data, go to IDLE.
  - A further `flush` in DRAIN sets `pc_mode` = 1 again and clears the FIFO; the state stays DRAIN.
- **FIFO**
  - Circular buffer with wrapping read/write pointers.
  - `instr_valid` = (count ≠ 0).
  - Pop when `instr_valid` && `instr_ready` && !`flush`.
  - A push and a pop in the same cycle leave count unchanged.
  - Overflow is impossible: issue requires count < DEPTH, and only one request is outstanding.
- **flush priority:** `flush` wins over push and pop in the same cycle. No word presented in a flush cycle is consumed.
- **Address arithmetic:** 32-bit; wrap from 0xFFFFFFFF to 0 is handled by the PC.

## Timing
- **Issue:** IDLE → REQ takes 1 cycle, so `mem_req` rises the cycle after the issue decision.
- **Return:** the cycle after `mem_ack`, the word is visible at the head (if the FIFO was empty) and PC = old + 1.
- **Throughput:** minimum 2 cycles per word with a zero-wait memory (REQ, IDLE alternate).
- **First fetch after reset:** the first cycle with `reset_n` = 1 is IDLE. `mem_req` = 1 with `mem_addr` = 0 in the following cycle.
- **Flush:** the PC loads the target at the flush edge. With nothing in flight, the first request to the target appears 2 cycles after `flush`. Through DRAIN, it appears 2 cycles after the discarded ack.
- **Decoder:** `instr_data` and `instr_pc` are stable while `instr_valid` = 1 and `instr_ready` = 0.

## Test plan
- **Reset and stream:** hold `reset_n` = 0 for 3 cycles with memory returning `mem_rdata` = addr ^ 0xA5A5A5A5 one cycle after each request, and `instr_ready` = 1.
  - Required: `pc_mode` = 0 during reset.
  - Required: words for addresses 0, 1, 2, 3 are delivered in order with the correct `instr_pc`.
  - Required: `pc_mode` pulses 4 exactly once per ack.
- **Backpressure:** `instr_ready` = 0 with DEPTH = 2.
  - Required: exactly 2 words are buffered, `mem_req` stays 0, and PC = 2.
  - Required: after raising `instr_ready`, fetch resumes at address 2 with no loss or duplication.
- **Flush while idle:** assert `flush` with the FIFO holding 2 words and the bus carrying 0x100.
  - Required: `instr_valid` = 0 next cycle and `pc_mode` = 1 on the flush cycle.
  - Required: the next `mem_addr` is 0x100.
- **Flush in flight:** assert `flush` in REQ while memory delays the ack by 4 cycles.
  - Required: the state goes to DRAIN and the late word is discarded, never presented.
  - Required: the next request is to the target.
- **Flush and ack together:** assert `flush` in the same cycle as `mem_ack`.
  - Required: the data is dropped, `pc_mode` = 1 (not 4), and the FIFO is empty.
- **Reset mid-REQ:** deassert `reset_n` while `mem_req` = 1.
  - Required: `mem_req` = 0 next cycle, and fetch restarts at address 0 after release.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: PC control, instruction-memory read port and decoder handshake.
// The master side is the fetch unit; the slave side is the surrounding core/memory.
interface instr_fetch_if;
  logic [31:0] pc_value;
  logic [2:0]  pc_mode;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    input  pc_value, flush, mem_ack, mem_rdata, instr_ready,
    output pc_mode, mem_req, mem_addr, instr_valid, instr_data, instr_pc
  );

  modport slave (
    output pc_value, flush, mem_ack, mem_rdata, instr_ready,
    input  pc_mode, mem_req, mem_addr, instr_valid, instr_data, instr_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding memory reads into a small address-tagged
// FIFO feeding the decoder; flush drops buffered and in-flight words.
module instr_fetch #(
  parameter int DEPTH = 2
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  instr_fetch_if.master io_fetch
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [2:0] PC_RESET = 3'd0;
  localparam logic [2:0] PC_LOAD  = 3'd1;
  localparam logic [2:0] PC_HOLD  = 3'd3;
  localparam logic [2:0] PC_INC   = 3'd4;

  state_t             r_state;
  state_t             w_state_next;
  logic [31:0]        r_mem_addr;
  logic [31:0]        r_fifo_data [DEPTH];
  logic [31:0]        r_fifo_pc   [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic w_valid;
  logic w_has_room;
  logic w_push;
  logic w_pop;
  logic w_issue;

  assign w_valid    = (r_count != '0);
  assign w_has_room = (r_count < CNT_W'(DEPTH));
  // flush outranks both push and pop so nothing is consumed or kept in a flush cycle
  assign w_push  = (r_state == S_REQ) && io_fetch.mem_ack && !io_fetch.flush;
  assign w_pop   = w_valid && io_fetch.instr_ready && !io_fetch.flush;
  assign w_issue = (r_state == S_IDLE) && !io_fetch.flush && w_has_room;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          w_state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (io_fetch.mem_ack) begin
          w_state_next = S_IDLE;
        end else if (io_fetch.flush) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (io_fetch.mem_ack) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    io_fetch.pc_mode = PC_HOLD;
    io_fetch.mem_req = (r_state == S_REQ) || (r_state == S_DRAIN);
    if (!i_reset_n) begin
      io_fetch.pc_mode = PC_RESET;
    end else if (io_fetch.flush) begin
      io_fetch.pc_mode = PC_LOAD;
    end else if ((r_state == S_REQ) && io_fetch.mem_ack) begin
      io_fetch.pc_mode = PC_INC;
    end
  end

  assign io_fetch.mem_addr = r_mem_addr;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_mem_addr <= '0;
    end else if (w_issue) begin
      r_mem_addr <= io_fetch.pc_value;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n || io_fetch.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: count gates visibility of every entry.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge i_clock) begin
      if (w_push && (r_wr_ptr == PTR_W'(gi))) begin
        r_fifo_data[gi] <= io_fetch.mem_rdata;
        r_fifo_pc[gi]   <= r_mem_addr;
      end
    end
  end

  assign io_fetch.instr_valid = w_valid;
  assign io_fetch.instr_data  = w_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign io_fetch.instr_pc    = w_valid ? r_fifo_pc[r_rd_ptr]   : '0;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a PC model, a latency-programmable memory and a
// delivery monitor surround the DUT; expected words are addr ^ 0xA5A5A5A5.
module tb_instr_fetch;
  localparam int DEPTH = 2;
  localparam logic [31:0] PAT = 32'hA5A5A5A5;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  instr_fetch_if fetch ();

  instr_fetch #(.DEPTH(DEPTH)) dut (
    .i_clock   (clock),
    .i_reset_n (reset_n),
    .io_fetch  (fetch)
  );

  // Program counter model driven by pc_mode
  logic [31:0] tb_pc = 32'd0;
  logic [31:0] bus_target = 32'd0;
  assign fetch.pc_value = tb_pc;
  always @(posedge clock) begin
    case (fetch.pc_mode)
      3'd0:    tb_pc <= 32'd0;
      3'd1:    tb_pc <= bus_target;
      3'd4:    tb_pc <= tb_pc + 32'd1;
      default: tb_pc <= tb_pc;
    endcase
  end

  // Memory: ack after `lat` extra request cycles, data = addr ^ PAT
  int lat = 1;
  initial begin
    int wcnt;
    wcnt = 0;
    fetch.mem_ack = 1'b0;
    fetch.mem_rdata = 32'd0;
    forever begin
      @(posedge clock);
      #1;
      if (fetch.mem_ack) begin
        fetch.mem_ack = 1'b0;
        wcnt = 0;
      end else if (fetch.mem_req) begin
        if (wcnt >= lat) begin
          fetch.mem_ack = 1'b1;
          fetch.mem_rdata = fetch.mem_addr ^ PAT;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } word_t;

  word_t got_q[$];
  int n_ack = 0;
  int n_inc = 0;

  always @(posedge clock) begin
    if (reset_n && fetch.instr_valid && fetch.instr_ready && !fetch.flush) begin
      got_q.push_back('{pc: fetch.instr_pc, data: fetch.instr_data});
      $display("word pc=%h data=%h", fetch.instr_pc, fetch.instr_data);
    end
    if (reset_n && fetch.mem_req && fetch.mem_ack) n_ack <= n_ack + 1;
    if (fetch.pc_mode == 3'd4) n_inc <= n_inc + 1;
  end

  int n_checks = 0;
  int n_errors = 0;
  int base = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_words(input int need, input int budget);
    int k;
    k = 0;
    while ((got_q.size() < base + need) && (k < budget)) begin
      tick();
      k++;
    end
    check("wait_words", 32'(got_q.size() >= base + need), 32'd1);
  endtask

  task automatic check_words(input string tag, input int n, input logic [31:0] start_pc);
    for (int i = 0; i < n; i++) begin
      if (got_q.size() > base + i) begin
        check({tag, "_pc"},   got_q[base + i].pc,   start_pc + 32'(i));
        check({tag, "_data"}, got_q[base + i].data, (start_pc + 32'(i)) ^ PAT);
      end
    end
  endtask

  task automatic wait_ack(input int budget);
    int k;
    k = 0;
    while (!fetch.mem_ack && (k < budget)) begin
      tick();
      k++;
    end
    check("wait_ack", 32'(fetch.mem_ack), 32'd1);
  endtask

  initial begin
    int ack0;
    int inc0;
    int k;
    fetch.flush = 1'b0;
    fetch.instr_ready = 1'b1;

    // Reset and stream
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_pc_mode", 32'(fetch.pc_mode), 32'd0);
    end
    check("rst_mem_req", 32'(fetch.mem_req), 32'd0);
    check("rst_valid", 32'(fetch.instr_valid), 32'd0);
    check("rst_data", fetch.instr_data, 32'd0);
    check("rst_ipc", fetch.instr_pc, 32'd0);
    check("rst_addr", fetch.mem_addr, 32'd0);
    reset_n = 1'b1;
    #1;
    check("idle_first", 32'(fetch.mem_req), 32'd0);
    base = got_q.size();
    ack0 = n_ack;
    inc0 = n_inc;
    tick();
    check("first_req", 32'(fetch.mem_req), 32'd1);
    check("first_addr", fetch.mem_addr, 32'd0);
    wait_words(4, 60);
    check_words("stream", 4, 32'd0);
    check("inc_per_ack", 32'(n_inc - inc0), 32'(n_ack - ack0));
    check("ack_seen", 32'((n_ack - ack0) >= 4), 32'd1);

    // Backpressure from a fresh reset
    reset_n = 1'b0;
    fetch.instr_ready = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    base = got_q.size();
    repeat (20) tick();
    check("bp_valid", 32'(fetch.instr_valid), 32'd1);
    check("bp_req", 32'(fetch.mem_req), 32'd0);
    check("bp_pc", tb_pc, 32'd2);
    check("bp_head_pc", fetch.instr_pc, 32'd0);
    check("bp_head_data", fetch.instr_data, PAT);
    check("bp_none_taken", 32'(got_q.size() - base), 32'd0);
    fetch.instr_ready = 1'b1;
    wait_words(4, 60);
    check_words("resume", 4, 32'd0);

    // Flush while idle with a full FIFO
    fetch.instr_ready = 1'b0;
    repeat (20) tick();
    check("fi_full", 32'(fetch.instr_valid), 32'd1);
    check("fi_idle", 32'(fetch.mem_req), 32'd0);
    base = got_q.size();
    bus_target = 32'h100;
    fetch.flush = 1'b1;
    #1;
    check("fi_pc_mode", 32'(fetch.pc_mode), 32'd1);
    lat = 4;
    tick();
    fetch.flush = 1'b0;
    #1;
    check("fi_valid", 32'(fetch.instr_valid), 32'd0);
    check("fi_pc", tb_pc, 32'h100);
    check("fi_no_req_yet", 32'(fetch.mem_req), 32'd0);
    tick();
    #1;
    check("fi_req", 32'(fetch.mem_req), 32'd1);
    check("fi_addr", fetch.mem_addr, 32'h100);

    // Flush in flight: late ack must be swallowed by DRAIN
    fetch.instr_ready = 1'b1;
    bus_target = 32'h200;
    fetch.flush = 1'b1;
    #1;
    check("ff_no_ack", 32'(fetch.mem_ack), 32'd0);
    check("ff_pc_mode", 32'(fetch.pc_mode), 32'd1);
    tick();
    fetch.flush = 1'b0;
    #1;
    check("ff_drain_req", 32'(fetch.mem_req), 32'd1);
    check("ff_drain_mode", 32'(fetch.pc_mode), 32'd3);
    check("ff_valid", 32'(fetch.instr_valid), 32'd0);
    check("ff_pc", tb_pc, 32'h200);
    wait_ack(20);
    tick();
    #1;
    check("ff_idle", 32'(fetch.mem_req), 32'd0);
    tick();
    #1;
    check("ff_req", 32'(fetch.mem_req), 32'd1);
    check("ff_addr", fetch.mem_addr, 32'h200);
    wait_words(1, 30);
    check_words("ff_next", 1, 32'h200);
    lat = 1;

    // Flush coinciding with ack
    wait_ack(20);
    base = got_q.size();
    bus_target = 32'h300;
    fetch.flush = 1'b1;
    #1;
    check("fa_pc_mode", 32'(fetch.pc_mode), 32'd1);
    tick();
    fetch.flush = 1'b0;
    #1;
    check("fa_valid", 32'(fetch.instr_valid), 32'd0);
    check("fa_idle", 32'(fetch.mem_req), 32'd0);
    check("fa_pc", tb_pc, 32'h300);
    tick();
    #1;
    check("fa_addr", fetch.mem_addr, 32'h300);
    wait_words(1, 30);
    check_words("fa_next", 1, 32'h300);

    // Reset while a request is outstanding
    k = 0;
    while (!(fetch.mem_req && !fetch.mem_ack) && (k < 20)) begin
      tick();
      k++;
    end
    check("rr_in_req", 32'(fetch.mem_req), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rr_pc_mode", 32'(fetch.pc_mode), 32'd0);
    tick();
    check("rr_req", 32'(fetch.mem_req), 32'd0);
    check("rr_valid", 32'(fetch.instr_valid), 32'd0);
    reset_n = 1'b1;
    base = got_q.size();
    wait_words(2, 40);
    check_words("rr_restart", 2, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
